// File: rtl/thread_sched.sv
`default_nettype none
// thread_sched: 8-thread round-robin fetch scheduler tracking DEAD/RUN/SLEEP/MISS per thread.
// Optional fetch-idle counter built only when THREAD_SCHED_PERF_EN is defined.
module thread_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        kill,
   input  logic        sleep,
   input  logic        d_miss,
   input  logic [2:0]  trd_wb,
   input  logic        miss_done,
   input  logic [2:0]  miss_trd,
   input  logic        wake,
   input  logic [2:0]  wake_trd,
   input  logic        spawn,
   input  logic [2:0]  spawn_trd,
   input  logic        stall,
   output logic [2:0]  trd_if,
   output logic        if_valid,
   output logic [7:0]  run_mask,
   output logic [15:0] idle_cnt
);

   typedef enum logic [1:0] {
      ST_DEAD  = 2'b00,
      ST_RUN   = 2'b01,
      ST_SLEEP = 2'b10,
      ST_MISS  = 2'b11
   } thr_st_t;

   thr_st_t    r_st  [8];
   thr_st_t    w_nst [8];
   logic [7:0] w_nrun;
   logic [2:0] r_trd;
   logic [2:0] w_trd_nxt;
   logic [2:0] w_cand;
   logic       r_vld;
   logic       w_vld_nxt;
   logic       w_wb_any;

   assign w_wb_any = kill | d_miss | sleep;

   // A writeback event on a thread masks any miss_done/wake/spawn aimed at it.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_nst[i] = r_st[i];
         if (w_wb_any && (trd_wb == 3'(i))) begin
            if (r_st[i] == ST_RUN) begin
               if (kill)
                  w_nst[i] = ST_DEAD;
               else if (d_miss)
                  w_nst[i] = ST_MISS;
               else
                  w_nst[i] = ST_SLEEP;
            end
         end else begin
            if (miss_done && (miss_trd == 3'(i)) && (r_st[i] == ST_MISS))
               w_nst[i] = ST_RUN;
            if (wake && (wake_trd == 3'(i)) && (r_st[i] == ST_SLEEP))
               w_nst[i] = ST_RUN;
            if (spawn && (spawn_trd == 3'(i)) && (r_st[i] == ST_DEAD))
               w_nst[i] = ST_RUN;
         end
      end
   end

   always_comb begin
      w_nrun = '0;
      for (int i = 0; i < 8; i++)
         w_nrun[i] = (w_nst[i] == ST_RUN);
   end

   // Scan downward so the nearest RUN thread after r_trd wins; offset 8 wraps to r_trd itself.
   always_comb begin
      w_trd_nxt = r_trd;
      w_vld_nxt = 1'b0;
      w_cand    = r_trd;
      if (stall) begin
         w_vld_nxt = w_nrun[r_trd];
      end else begin
         for (int k = 8; k >= 1; k--) begin
            w_cand = r_trd + 3'(k);
            if (w_nrun[w_cand]) begin
               w_trd_nxt = w_cand;
               w_vld_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++)
            r_st[i] <= (i == 0) ? ST_RUN : ST_DEAD;
         r_trd <= 3'd0;
         r_vld <= 1'b1;
      end else begin
         for (int i = 0; i < 8; i++)
            r_st[i] <= w_nst[i];
         r_trd <= w_trd_nxt;
         r_vld <= w_vld_nxt;
      end
   end

   always_comb begin
      run_mask = '0;
      for (int i = 0; i < 8; i++)
         run_mask[i] = (r_st[i] == ST_RUN);
   end

   assign trd_if   = r_trd;
   assign if_valid = r_vld;

`ifdef THREAD_SCHED_PERF_EN
   logic [15:0] r_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_idle <= 16'h0000;
      else if (!r_vld && (r_idle != 16'hFFFF))
         r_idle <= r_idle + 16'd1;
   end

   assign idle_cnt = r_idle;
`else
   assign idle_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thread_sched.sv
`default_nettype none
// tb_thread_sched: scoreboard bench for thread_sched with directed scenarios and random traffic.
module tb_thread_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        kill = 1'b0, sleep = 1'b0, d_miss = 1'b0;
   logic        miss_done = 1'b0, wake = 1'b0, spawn = 1'b0, stall = 1'b0;
   logic [2:0]  trd_wb = 3'd0, miss_trd = 3'd0, wake_trd = 3'd0, spawn_trd = 3'd0;
   logic [2:0]  trd_if;
   logic        if_valid;
   logic [7:0]  run_mask;
   logic [15:0] idle_cnt;

   int nchk = 0;
   int nerr = 0;

   localparam int c_DEAD  = 0;
   localparam int c_RUN   = 1;
   localparam int c_SLEEP = 2;
   localparam int c_MISS  = 3;

   always #5 clk = ~clk;

   thread_sched dut (
      .clk(clk), .rst_n(rst_n),
      .kill(kill), .sleep(sleep), .d_miss(d_miss), .trd_wb(trd_wb),
      .miss_done(miss_done), .miss_trd(miss_trd),
      .wake(wake), .wake_trd(wake_trd),
      .spawn(spawn), .spawn_trd(spawn_trd),
      .stall(stall),
      .trd_if(trd_if), .if_valid(if_valid), .run_mask(run_mask), .idle_cnt(idle_cnt)
   );

   typedef struct packed {
      logic [7:0]  mask;
      logic [2:0]  trd;
      logic        vld;
      logic [15:0] idle;
   } exp_t;

   exp_t q[$];
   exp_t me;

   // Reference model: thread states as plain ints, fetch pointer, valid flag, idle count.
   int ms[8];
   int mtrd;
   bit mval;
   int midle;

   task automatic model_reset();
      for (int t = 0; t < 8; t++) ms[t] = c_DEAD;
      ms[0] = c_RUN;
      mtrd  = 0;
      mval  = 1'b1;
      midle = 0;
   endtask

   task automatic model_step();
      int ns[8];
      bit wb;
      bit found;
      wb = kill | d_miss | sleep;
`ifdef THREAD_SCHED_PERF_EN
      if (!mval && midle < 65535) midle++;
`endif
      for (int t = 0; t < 8; t++) begin
         ns[t] = ms[t];
         if (wb && int'(trd_wb) == t) begin
            if (ms[t] == c_RUN) ns[t] = kill ? c_DEAD : (d_miss ? c_MISS : c_SLEEP);
         end else if (miss_done && int'(miss_trd) == t && ms[t] == c_MISS) ns[t] = c_RUN;
         else if (wake && int'(wake_trd) == t && ms[t] == c_SLEEP) ns[t] = c_RUN;
         else if (spawn && int'(spawn_trd) == t && ms[t] == c_DEAD) ns[t] = c_RUN;
      end
      if (stall) begin
         mval = (ns[mtrd] == c_RUN);
      end else begin
         found = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            if (!found && ns[(mtrd + k) % 8] == c_RUN) begin
               mtrd  = (mtrd + k) % 8;
               found = 1'b1;
            end
         end
         mval = found;
      end
      ms = ns;
   endtask

   function automatic logic [7:0] model_mask();
      logic [7:0] m;
      m = '0;
      for (int t = 0; t < 8; t++) m[t] = (ms[t] == c_RUN);
      return m;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Called with inputs set, just after a falling edge; returns at the next falling edge.
   task automatic step();
      exp_t e;
      model_step();
      e.mask = model_mask();
      e.trd  = 3'(mtrd);
      e.vld  = mval;
      e.idle = 16'(midle);
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic clear_in();
      kill = 0; sleep = 0; d_miss = 0; trd_wb = 0;
      miss_done = 0; miss_trd = 0; wake = 0; wake_trd = 0;
      spawn = 0; spawn_trd = 0; stall = 0;
   endtask

   task automatic ev(input logic k, input logic s, input logic dm, input logic [2:0] wb,
                     input logic md, input logic [2:0] mt, input logic wk, input logic [2:0] wt,
                     input logic sp, input logic [2:0] spt, input logic st);
      kill = k; sleep = s; d_miss = dm; trd_wb = wb;
      miss_done = md; miss_trd = mt; wake = wk; wake_trd = wt;
      spawn = sp; spawn_trd = spt; stall = st;
      step();
      clear_in();
   endtask

   // Reset asserted mid-cycle; outputs must snap to reset values without a clock edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("async reset run_mask", int'(run_mask), 'h01);
      chk("async reset trd_if", int'(trd_if), 0);
      chk("async reset if_valid", int'(if_valid), 1);
      chk("async reset idle_cnt", int'(idle_cnt), 0);
      q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
         me = q.pop_front();
         nchk++;
         if ({run_mask, trd_if, if_valid, idle_cnt} !== me) begin
            nerr++;
            $display("FAIL scoreboard: got mask=%h trd=%0d vld=%b idle=%0d, required mask=%h trd=%0d vld=%b idle=%0d",
                     run_mask, trd_if, if_valid, idle_cnt, me.mask, me.trd, me.vld, me.idle);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset run_mask", int'(run_mask), 'h01);
      chk("reset trd_if", int'(trd_if), 0);
      chk("reset if_valid", int'(if_valid), 1);
      chk("reset idle_cnt", int'(idle_cnt), 0);

      // Spawn 2 then 5: fetch order 0,2,5,0,2,5
      ev(0,0,0,0, 0,0, 0,0, 1,2, 0);
      chk("rr trd 2", int'(trd_if), 2);
      ev(0,0,0,0, 0,0, 0,0, 1,5, 0);
      chk("rr trd 5", int'(trd_if), 5);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 0);
      chk("rr trd 0", int'(trd_if), 0);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 0);
      chk("rr trd 2b", int'(trd_if), 2);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 0);
      chk("rr trd 5b", int'(trd_if), 5);
      chk("rr valid", int'(if_valid), 1);

      // Data miss on 2 then miss return
      do_reset();
      ev(0,0,0,0, 0,0, 0,0, 1,2, 0);
      chk("miss spawn mask", int'(run_mask), 'h05);
      ev(0,0,1,2, 0,0, 0,0, 0,0, 0);
      chk("miss mask", int'(run_mask), 'h01);
      chk("miss trd", int'(trd_if), 0);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 0);
      chk("miss only 0", int'(trd_if), 0);
      ev(0,0,0,0, 1,2, 0,0, 0,0, 0);
      chk("miss return mask", int'(run_mask), 'h05);
      chk("miss return trd", int'(trd_if), 2);

      // Kill beats sleep on the only RUN thread
      do_reset();
      ev(1,1,0,0, 0,0, 0,0, 0,0, 0);
      chk("kill mask", int'(run_mask), 'h00);
      chk("kill valid", int'(if_valid), 0);
      chk("kill trd", int'(trd_if), 0);
      repeat (3) ev(0,0,0,0, 0,0, 0,0, 0,0, 0);
`ifdef THREAD_SCHED_PERF_EN
      chk("idle count", int'(idle_cnt), 3);
`else
      chk("idle count", int'(idle_cnt), 0);
`endif
      // wake on a DEAD thread is ignored
      ev(0,0,0,0, 0,0, 1,0, 0,0, 0);
      chk("wake dead ignored", int'(run_mask), 'h00);

      // Stall holds trd_if; sleeping the held thread drops valid
      do_reset();
      ev(0,0,0,0, 0,0, 0,0, 1,1, 0);
      chk("stall pre trd", int'(trd_if), 1);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 1);
      chk("stall1 trd", int'(trd_if), 1);
      chk("stall1 valid", int'(if_valid), 1);
      ev(0,1,0,1, 0,0, 0,0, 0,0, 1);
      chk("stall2 trd", int'(trd_if), 1);
      chk("stall2 valid", int'(if_valid), 0);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 1);
      chk("stall3 trd", int'(trd_if), 1);
      ev(0,0,0,0, 0,0, 0,0, 0,0, 0);
      chk("unstall trd", int'(trd_if), 0);
      chk("unstall valid", int'(if_valid), 1);
      // wake thread 1 from SLEEP
      ev(0,0,0,0, 0,0, 1,1, 0,0, 0);
      chk("wake sleep mask", int'(run_mask), 'h03);

      // Kill and wake on the same thread: writeback wins
      do_reset();
      ev(0,0,0,0, 0,0, 0,0, 1,3, 0);
      chk("kw spawn mask", int'(run_mask), 'h09);
      ev(1,0,0,3, 0,0, 1,3, 0,0, 0);
      chk("kw kill mask", int'(run_mask), 'h01);
      ev(0,0,0,0, 0,0, 1,3, 0,0, 0);
      chk("kw wake dead", int'(run_mask), 'h01);

      // Threads 1-7 RUN then asynchronous reset
      do_reset();
      ev(1,0,0,0, 0,0, 0,0, 0,0, 0);
      for (int t = 1; t < 8; t++) ev(0,0,0,0, 0,0, 0,0, 1,3'(t), 0);
      chk("all but 0 mask", int'(run_mask), 'hFE);
      do_reset();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         kill      = ($urandom_range(0, 9) == 0);
         d_miss    = ($urandom_range(0, 5) == 0);
         sleep     = ($urandom_range(0, 5) == 0);
         trd_wb    = 3'($urandom_range(0, 7));
         miss_done = ($urandom_range(0, 2) == 0);
         miss_trd  = 3'($urandom_range(0, 7));
         wake      = ($urandom_range(0, 2) == 0);
         wake_trd  = 3'($urandom_range(0, 7));
         spawn     = ($urandom_range(0, 2) == 0);
         spawn_trd = 3'($urandom_range(0, 7));
         stall     = ($urandom_range(0, 3) == 0);
         step();
         clear_in();
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      @(negedge clk);
      chk("queue drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
`default_nettype wire
